// File: rtl/uart_rx_sync_if.sv
// Signal bundle between the 8N1 receiver and its host: serial line in, byte/status out.
// The slave modport is the receiver; the master modport is the line driver and byte consumer.
interface uart_rx_sync_if;
  logic       i_Rx_Serial;
  logic       o_Rx_DV;
  logic [7:0] o_Rx_Byte;
  logic       o_Rx_Frame_Err;
  logic       o_Rx_Active;

  modport slave (
    input  i_Rx_Serial,
    output o_Rx_DV,
    output o_Rx_Byte,
    output o_Rx_Frame_Err,
    output o_Rx_Active
  );

  modport master (
    output i_Rx_Serial,
    input  o_Rx_DV,
    input  o_Rx_Byte,
    input  o_Rx_Frame_Err,
    input  o_Rx_Active
  );
endinterface

// File: rtl/uart_rx_sync.sv
// 8N1 UART receiver with a two-flop line synchronizer and mid-bit sampling.
// Flags framing errors and parks in BREAK while the line stays low, so a held-low line reports only once.
module uart_rx_sync #(
  parameter int CLKS_PER_BIT = 234
) (
  input logic           i_Clock,
  input logic           i_Reset,
  uart_rx_sync_if.slave rx
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int H     = (CLKS_PER_BIT - 1) / 2;

  localparam logic [CNT_W-1:0] HALF_LIM = CNT_W'(H);
  localparam logic [CNT_W-1:0] BIT_LIM  = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] START   = 3'd1;
  localparam logic [2:0] DATA    = 3'd2;
  localparam logic [2:0] STOP    = 3'd3;
  localparam logic [2:0] CLEANUP = 3'd4;
  localparam logic [2:0] BREAK   = 3'd5;

  logic             rx_meta;
  logic             rx_s;
  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             rx_dv;
  logic [7:0]       rx_byte;
  logic             frame_err;
  logic             active;

  // Both stages reset to the idle (high) level so reset never fakes a start edge.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx.i_Rx_Serial;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rx_dv     <= 1'b0;
      rx_byte   <= 8'h00;
      frame_err <= 1'b0;
      active    <= 1'b0;
    end else begin
      rx_dv     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (!rx_s) begin
            state  <= START;
            active <= 1'b1;
          end
        end
        // A start bit that is high again at mid-bit was a glitch.
        START: begin
          if (cnt == HALF_LIM) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state  <= IDLE;
              active <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_LIM) begin
            cnt            <= '0;
            shift[bit_idx] <= rx_s;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              state   <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // A low stop bit leaves the last good byte untouched.
        STOP: begin
          if (cnt == BIT_LIM) begin
            cnt <= '0;
            if (rx_s) begin
              rx_byte <= shift;
              rx_dv   <= 1'b1;
              state   <= CLEANUP;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CLEANUP: begin
          state  <= IDLE;
          active <= 1'b0;
        end
        BREAK: begin
          if (rx_s) begin
            state  <= IDLE;
            active <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          bit_idx <= '0;
          active  <= 1'b0;
        end
      endcase
    end
  end

  assign rx.o_Rx_DV        = rx_dv;
  assign rx.o_Rx_Byte      = rx_byte;
  assign rx.o_Rx_Frame_Err = frame_err;
  assign rx.o_Rx_Active    = active;

endmodule
